// File: rtl/bram_skip_writer_l9_pkg.sv
// Shared constants for the layer-9 skip buffer: FSM encoding, tile geometry and address width.
// Used by both the skip writer and the skip-read address logic.
package bram_skip_writer_l9_pkg;

    localparam int TILE_COUNT     = 8;
    localparam int TILE_EDGE      = 8;
    localparam int BEATS_PER_FILL = 512;
    localparam int ADDR_W         = 10;
    localparam int CNT_W          = 3;
    localparam int FIELD_W        = ADDR_W / 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] Z_FIRST  = 3'd1;
    localparam logic [CNT_W-1:0] EDGE_MAX = 3'(TILE_EDGE - 1);

    // Tiles are stacked two per row band in the order 1,2 | 3,4 | 5,6 | 7,0.
    function automatic logic [FIELD_W-1:0] row_offset(input logic [CNT_W-1:0] z);
        logic [FIELD_W-1:0] off;
        case (z)
            3'd1, 3'd2: off = 5'd0;
            3'd3, 3'd4: off = 5'd8;
            3'd5, 3'd6: off = 5'd16;
            default:    off = 5'd24;
        endcase
        return off;
    endfunction

    function automatic logic [FIELD_W-1:0] col_offset(input logic [CNT_W-1:0] z);
        return z[0] ? 5'd0 : 5'd16;
    endfunction

endpackage

// File: rtl/bram_skip_writer_l9_wmap.sv
// Combinational (z,x,y) -> dual-port skip-BRAM write address mapping.
// Port 2 writes the column band 8 words to the right of port 1.
module bram_skip_wmap_l9
    import bram_skip_writer_l9_pkg::*;
(
    input  logic [2:0] z,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [9:0] waddr1,
    output logic [9:0] waddr2
);

    logic [FIELD_W-1:0] row;
    logic [FIELD_W-1:0] col1;
    logic [FIELD_W-1:0] col2;

    always_comb begin
        row    = {2'b00, x} + row_offset(z);
        col1   = {2'b00, y} + col_offset(z);
        col2   = col1 + 5'd8;
        waddr1 = {row, col1};
        waddr2 = {row, col2};
    end

endmodule

// File: rtl/bram_skip_writer_l9.sv
// Layer-9 skip-buffer writer: streams 512 pixel-pair beats into 1024 skip-BRAM words.
// Optional SKIP_WR_OVERRUN_CHK_EN adds a sticky overrun_err flag for beats offered outside a fill.
module bram_skip_writer_l9
    import bram_skip_writer_l9_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    output logic              BRAM_skip_we1,
    output logic              BRAM_skip_we2,
    output logic [9:0]        BRAM_skip_waddr1,
    output logic [9:0]        BRAM_skip_waddr2,
    output logic [DATA_W-1:0] BRAM_skip_wdata1,
    output logic [DATA_W-1:0] BRAM_skip_wdata2,
    output logic              busy,
`ifdef SKIP_WR_OVERRUN_CHK_EN
    output logic              overrun_err,
`endif
    output logic              done
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  z_q, z_d, x_q, x_d, y_q, y_d;
    logic              we_q, we_d;
    logic [9:0]        waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic [9:0]        map_waddr1, map_waddr2;
    logic              accept, last_beat;

    bram_skip_wmap_l9 u_wmap (
        .z      (z_q),
        .x      (x_q),
        .y      (y_q),
        .waddr1 (map_waddr1),
        .waddr2 (map_waddr2)
    );

    assign accept    = in_valid && (state_q == ST_WRITE);
    assign last_beat = (z_q == 3'd0) && (x_q == EDGE_MAX) && (y_q == EDGE_MAX);

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        x_d      = x_q;
        y_d      = y_q;
        we_d     = 1'b0;
        waddr1_d = waddr1_q;
        waddr2_d = waddr2_q;
        wdata1_d = wdata1_q;
        wdata2_d = wdata2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WRITE;
                    z_d     = Z_FIRST;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    we_d     = 1'b1;
                    waddr1_d = map_waddr1;
                    waddr2_d = map_waddr2;
                    wdata1_d = in_data1;
                    wdata2_d = in_data2;
                    // y is fastest, then x, then tile z (z wraps 7 -> 0 -> 1)
                    y_d = y_q + 3'd1;
                    if (y_q == EDGE_MAX) begin
                        x_d = x_q + 3'd1;
                        if (x_q == EDGE_MAX) begin
                            z_d = z_q + 3'd1;
                        end
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            z_q      <= Z_FIRST;
            x_q      <= '0;
            y_q      <= '0;
            we_q     <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            x_q      <= x_d;
            y_q      <= y_d;
            we_q     <= we_d;
            waddr1_q <= waddr1_d;
            waddr2_q <= waddr2_d;
            wdata1_q <= wdata1_d;
            wdata2_q <= wdata2_d;
        end
    end

`ifdef SKIP_WR_OVERRUN_CHK_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (start) begin
            overrun_d = 1'b0;
        end else if (in_valid && (state_q != ST_WRITE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_err = overrun_q;
`endif

    assign in_ready         = (state_q == ST_WRITE);
    assign busy             = (state_q == ST_WRITE) || (state_q == ST_DONE);
    assign done             = (state_q == ST_DONE);
    assign BRAM_skip_we1    = we_q;
    assign BRAM_skip_we2    = we_q;
    assign BRAM_skip_waddr1 = waddr1_q;
    assign BRAM_skip_waddr2 = waddr2_q;
    assign BRAM_skip_wdata1 = wdata1_q;
    assign BRAM_skip_wdata2 = wdata2_q;

endmodule

// File: tb/tb_bram_skip_writer_l9.sv
// Self-checking bench for bram_skip_writer_l9: directed address table, random-valid fills
// against an arithmetic address model, mid-fill reset and ignored start/valid cases.
module tb_bram_skip_writer_l9;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data1, in_data2;
    logic          we1, we2;
    logic [9:0]    waddr1, waddr2;
    logic [DW-1:0] wdata1, wdata2;
    logic          busy, done;
`ifdef SKIP_WR_OVERRUN_CHK_EN
    logic          overrun_err;
`endif

    bram_skip_writer_l9 #(.DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data1         (in_data1),
        .in_data2         (in_data2),
        .BRAM_skip_we1    (we1),
        .BRAM_skip_we2    (we2),
        .BRAM_skip_waddr1 (waddr1),
        .BRAM_skip_waddr2 (waddr2),
        .BRAM_skip_wdata1 (wdata1),
        .BRAM_skip_wdata2 (wdata2),
        .busy             (busy),
`ifdef SKIP_WR_OVERRUN_CHK_EN
        .overrun_err      (overrun_err),
`endif
        .done             (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int beat;
        int a1;
        int a2;
    } vec_t;
    vec_t tbl[6];

    bit            mon_on;
    int            beat_exp;
    logic [DW-1:0] dq1[$];
    logic [DW-1:0] dq2[$];
    bit            seen[1024];
    int            got1[512];
    int            got2[512];
    logic [DW-1:0] gotd1[512];
    logic [DW-1:0] gotd2[512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Address of beat n of a fill, straight from the tile/row/column rules.
    function automatic void exp_addr(input int n, output int a1, output int a2);
        int z, x, y, xo, yo;
        z  = ((n / 64) + 1) % 8;
        x  = (n / 8) % 8;
        y  = n % 8;
        xo = (z == 1 || z == 2) ? 0 : (z == 3 || z == 4) ? 8 : (z == 5 || z == 6) ? 16 : 24;
        yo = (z % 2 == 1) ? 0 : 16;
        a1 = (x + xo) * 32 + (y + yo);
        a2 = (x + xo) * 32 + (y + yo + 8);
    endfunction

    task automatic reset_sb();
        beat_exp = 0;
        dq1.delete();
        dq2.delete();
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    endtask

    task automatic monitor();
        int a1, a2;
        logic [DW-1:0] e1, e2;
        if (!mon_on) return;
        if (we1 || we2) begin
            chk("we_pair", {30'd0, we1, we2}, 32'd3);
            if (beat_exp >= 512) begin
                chk("extra_write", beat_exp, 511);
            end else begin
                exp_addr(beat_exp, a1, a2);
                $display("write beat=%0d waddr1=%0d waddr2=%0d wdata1=%h wdata2=%h done=%0b",
                         beat_exp, waddr1, waddr2, wdata1, wdata2, done);
                chk("waddr1", waddr1, a1);
                chk("waddr2", waddr2, a2);
                got1[beat_exp]  = waddr1;
                got2[beat_exp]  = waddr2;
                gotd1[beat_exp] = wdata1;
                gotd2[beat_exp] = wdata2;
                if (dq1.size() == 0) begin
                    chk("data_queue_empty", 0, 1);
                end else begin
                    e1 = dq1.pop_front();
                    e2 = dq2.pop_front();
                    chk("wdata1", wdata1, e1);
                    chk("wdata2", wdata2, e2);
                end
                chk("dup_addr1", seen[waddr1], 0);
                seen[waddr1] = 1'b1;
                chk("dup_addr2", seen[waddr2], 0);
                seen[waddr2] = 1'b1;
                chk("done_on_write", done, (beat_exp == 511) ? 1 : 0);
                chk("busy_on_write", busy, 1);
                beat_exp++;
            end
        end else begin
            chk("done_no_write", done, 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_fill(input int n_beats, input int pct, input int start_at);
        int pushed = 0;
        int cyc = 0;
        bit v;
        while (pushed < n_beats && cyc < 4000) begin
            v        = ($urandom_range(0, 99) < pct);
            in_valid = v;
            start    = (pushed == start_at);
            in_data1 = (pushed == 0) ? 16'h0011 : DW'($urandom);
            in_data2 = (pushed == 0) ? 16'h0022 : DW'($urandom);
            if (v && in_ready) begin
                dq1.push_back(in_data1);
                dq2.push_back(in_data2);
                pushed++;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        if (pushed < n_beats) chk("fill_timeout", pushed, n_beats);
    endtask

    task automatic finish_fill();
        int cnt = 0;
        chk("write_count", beat_exp, 512);
        for (int i = 0; i < 1024; i++) cnt += seen[i];
        chk("unique_addrs", cnt, 1024);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("start_in_done_ignored", in_ready, 0);
    endtask

    initial begin
        tbl[0] = '{0,   0,    8};
        tbl[1] = '{93,  117,  125};
        tbl[2] = '{511, 1015, 1023};
        tbl[3] = '{128, 256,  264};
        tbl[4] = '{457, 817,  825};
        tbl[5] = '{63,  231,  239};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data1 = '0; in_data2 = '0;
        mon_on = 1'b0;
        reset_sb();
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we1", we1, 0);
        chk("rst_we2", we2, 0);
        chk("rst_waddr1", waddr1, 0);
        chk("rst_waddr2", waddr2, 0);
        chk("rst_wdata1", wdata1, 0);
        chk("rst_wdata2", wdata2, 0);
`ifdef SKIP_WR_OVERRUN_CHK_EN
        chk("rst_overrun", overrun_err, 0);
`endif
        rst = 1'b0;
        tick();

        // Beats offered while idle must be ignored.
        in_valid = 1'b1;
        in_data1 = 16'hdead;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_valid_no_we", we1, 0);
            chk("idle_valid_no_ready", in_ready, 0);
        end
        in_valid = 1'b0;
`ifdef SKIP_WR_OVERRUN_CHK_EN
        chk("overrun_set", overrun_err, 1);
        tick();
        chk("overrun_held", overrun_err, 1);
`endif

        // Full fill, 50% valid, start re-pulsed mid-fill.
        mon_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
`ifdef SKIP_WR_OVERRUN_CHK_EN
        chk("overrun_cleared", overrun_err, 0);
`endif
        run_fill(512, 50, 300);
        finish_fill();
        for (int i = 0; i < 6; i++) begin
            $display("table beat=%0d waddr1=%0d waddr2=%0d", tbl[i].beat, got1[tbl[i].beat], got2[tbl[i].beat]);
            chk("tbl_waddr1", got1[tbl[i].beat], tbl[i].a1);
            chk("tbl_waddr2", got2[tbl[i].beat], tbl[i].a2);
        end
        chk("first_wdata1", gotd1[0], 16'h0011);
        chk("first_wdata2", gotd2[0], 16'h0022);

        // Reset after 200 beats abandons the fill.
        reset_sb();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_fill(200, 70, -1);
        chk("partial_count", beat_exp, 200);
        rst = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_we", we1, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_we", we1, 0);
        end
        in_valid = 1'b0;

        // Restart after reset begins again at tile 1, origin.
        reset_sb();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_fill(512, 50, -1);
        chk("restart_waddr1", got1[0], 0);
        chk("restart_waddr2", got2[0], 8);
        finish_fill();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_skip_writer_l9.md
BRAM_SKIP_WRITER_L9 -- requirements
Module: bram_skip_writer_l9

Interface
REQ-001 Parameter DATA_W, default 16, width of one skip-BRAM word.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle pulse that begins a layer-9 skip-buffer fill.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data1, in_data2  input  DATA_W each  pixel pair for port 1 and port 2.
REQ-008 BRAM_skip_we1, BRAM_skip_we2  output  1 each  write enables.
REQ-009 BRAM_skip_waddr1, BRAM_skip_waddr2  output  10 each  write addresses.
REQ-010 BRAM_skip_wdata1, BRAM_skip_wdata2  output  DATA_W each  write data.
REQ-011 busy  output  1  fill in progress; done  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states IDLE, WRITE, DONE; IDLE->WRITE on start; WRITE->DONE on acceptance of the 512th beat; DONE->IDLE after one cycle.
REQ-013 in_ready = 1 only in WRITE; beat accepted when in_valid && in_ready.
REQ-014 Counters: y (3 bits) fastest 0..7, then x (3 bits) 0..7, then tile z (3 bits) sequence 1,2,3,4,5,6,7,0; advance only on accepted beat.
REQ-015 Row offset XO: z in {1,2}->0, {3,4}->8, {5,6}->16, {7,0}->24.
REQ-016 Column offset YO: odd z->0, even z (incl. 0)->16.
REQ-017 waddr1 = {x+XO (5 bits), y+YO (5 bits)}; waddr2 = {x+XO, y+YO+8}; no carry beyond 5 bits per field.
REQ-018 Address, data, we registered: outputs reflect an accepted beat exactly 1 cycle after acceptance; we1=we2=1 for that cycle only, 0 otherwise.
REQ-019 Stall (in_valid=0 in WRITE): counters hold, we deasserted.
REQ-020 start while in WRITE or DONE is ignored.
REQ-021 in_valid outside WRITE is ignored; no write issued.
REQ-022 done asserted in DONE state, one cycle, coincident with the final write's we pulse; busy = 1 in WRITE and DONE.
REQ-023 Full fill writes all 1024 addresses exactly once.

Reset
REQ-024 rst asynchronously forces IDLE, x=y=0, z=1, we1=we2=0, waddr=0, wdata=0, in_ready=0, busy=0, done=0.
REQ-025 rst mid-fill abandons the fill; no further writes; next start restarts at z=1,x=0,y=0.

Configuration
REQ-026 Macro SKIP_WR_OVERRUN_CHK_EN: when defined, adds output overrun_err (1 bit), sticky set when in_valid=1 and state!=WRITE, cleared by rst or start; when undefined, port and logic absent.

Structure
REQ-027 Shared package holds state enum, tile count (8), tile edge (8), beats per fill (512), and address width (10) constants, shared with the skip-read address logic.
REQ-028 One sub-module natural: bram_skip_wmap_l9, combinational (z,x,y)->(waddr1,waddr2) mapping of REQ-015..017.

Verification
REQ-029 start, first beat z=1,x=0,y=0, data 0x0011/0x0022 -> next cycle waddr1=0, waddr2=8, we1=we2=1, wdata as given.
REQ-030 Beat at z=2,x=3,y=5 -> waddr1=117, waddr2=125.
REQ-031 Final beat z=0,x=7,y=7 -> waddr1=1015, waddr2=1023, done=1 same cycle, then IDLE with in_ready=0.
REQ-032 in_valid toggled 50% random over full fill -> exactly 512 we pulses, 1024 unique addresses, no skipped or repeated (z,x,y).
REQ-033 rst asserted after beat 200, then start -> first write again at waddr1=0, waddr2=8; start pulsed during WRITE -> counters unaffected.
REQ-034 With SKIP_WR_OVERRUN_CHK_EN, in_valid=1 in IDLE -> overrun_err=1 held until start.
